// File: rtl/op_decoder_seq_if.sv
// Op word bus from the packet deserialiser into the op decoder.
//   op       : op word (opcode byte in the top byte, sub byte below it)
//   op_valid : op qualifies this cycle; there is no backpressure
// The master modport drives the bus and the slave modport receives it.
interface op_decoder_seq_if #(
    parameter int unsigned OP_WIDTH = 16
) ();
    logic [OP_WIDTH-1:0] op;
    logic                op_valid;

    modport master (output op, output op_valid);
    modport slave  (input  op, input  op_valid);
endinterface

// File: rtl/op_decoder_seq.sv
// Registered NeXT op decoder with audio session tracking.
// It classifies each valid op word and tracks the audio session: the mode
// (44 or 22 kHz), the sample count and the inactivity timeout. A run of
// all-ones ops raises a reset request.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   bus (slave)    : op / op_valid from the deserialiser
//   power_on_r1, kbd_led_update, audio_start, audio_sample, sample_dropped,
//   all_1_packet, reset_req, unknown_op, audio_stop : one-cycle pulses
//   audio_active, audio_22khz : session levels
//   sample_count   : samples accepted in the current session (saturating)
module op_decoder_seq #(
    parameter int unsigned OP_WIDTH  = 16,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RESET_RUN = 2
) (
    input  logic               clk,
    input  logic               reset,
    op_decoder_seq_if.slave    bus,
    output logic               power_on_r1,
    output logic               kbd_led_update,
    output logic               audio_start,
    output logic               audio_sample,
    output logic               sample_dropped,
    output logic               all_1_packet,
    output logic               reset_req,
    output logic               unknown_op,
    output logic               audio_stop,
    output logic               audio_active,
    output logic               audio_22khz,
    output logic [CNT_W-1:0]   sample_count
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam int unsigned RUN_W = $clog2(RESET_RUN + 1);

    typedef enum logic [1:0] {IDLE, PLAY44, PLAY22} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               power_d, kbd_d, start_d, sample_d, dropped_d;
    logic               all1_d, rreq_d, unknown_d, stop_d, k22_d;
    logic [7:0]         opc, sub;
    logic               playing;

    assign opc     = bus.op[OP_WIDTH-1 -: 8];
    assign sub     = bus.op[OP_WIDTH-9 -: 8];
    assign playing = (state_q != IDLE);

    // State and all output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            tmo_q          <= '0;
            run_q          <= '0;
            sample_count   <= '0;
            power_on_r1    <= 1'b0;
            kbd_led_update <= 1'b0;
            audio_start    <= 1'b0;
            audio_sample   <= 1'b0;
            sample_dropped <= 1'b0;
            all_1_packet   <= 1'b0;
            reset_req      <= 1'b0;
            unknown_op     <= 1'b0;
            audio_stop     <= 1'b0;
            audio_active   <= 1'b0;
            audio_22khz    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            run_q          <= run_d;
            sample_count   <= cnt_d;
            power_on_r1    <= power_d;
            kbd_led_update <= kbd_d;
            audio_start    <= start_d;
            audio_sample   <= sample_d;
            sample_dropped <= dropped_d;
            all_1_packet   <= all1_d;
            reset_req      <= rreq_d;
            unknown_op     <= unknown_d;
            audio_stop     <= stop_d;
            audio_active   <= (state_d != IDLE);
            audio_22khz    <= k22_d;
        end
    end

    // Decode, session next-state and all-ones run tracking
    always_comb begin
        state_d   = state_q;
        cnt_d     = sample_count;
        tmo_d     = tmo_q;
        run_d     = run_q;
        power_d   = 1'b0;
        kbd_d     = 1'b0;
        start_d   = 1'b0;
        sample_d  = 1'b0;
        dropped_d = 1'b0;
        all1_d    = 1'b0;
        rreq_d    = 1'b0;
        unknown_d = 1'b0;
        stop_d    = 1'b0;
        k22_d     = audio_22khz;

        if (bus.op_valid) begin
            if (opc == 8'hc5 && sub == 8'hef)      power_d = 1'b1;
            else if (opc == 8'hc5 && sub == 8'h00) kbd_d = 1'b1;
            else if (opc == 8'h1f || opc == 8'h0f) start_d = 1'b1;
            else if (opc == 8'hc7) begin
                if (playing) sample_d  = 1'b1;
                else         dropped_d = 1'b1;
            end
            else if (opc == 8'hff)                 all1_d = 1'b1;
            else                                   unknown_d = 1'b1;
            if (opc != 8'hff) run_d = '0;
        end

        // A start or sample on the terminal timeout cycle pre-empts the stop
        if (start_d) begin
            state_d = (opc == 8'h1f) ? PLAY22 : PLAY44;
            cnt_d   = '0;
            tmo_d   = '0;
        end else if (sample_d) begin
            if (sample_count != {CNT_W{1'b1}}) cnt_d = sample_count + CNT_W'(1);
            tmo_d = '0;
        end else if (playing) begin
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                state_d = IDLE;
                stop_d  = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        // The terminal all-ones op in a run forces the session down
        if (all1_d) begin
            if (run_q == RUN_W'(RESET_RUN - 1)) begin
                rreq_d  = 1'b1;
                run_d   = '0;
                state_d = IDLE;
                cnt_d   = '0;
                tmo_d   = '0;
                if (playing) stop_d = 1'b1;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end

        if (state_d == PLAY22)      k22_d = 1'b1;
        else if (state_d == PLAY44) k22_d = 1'b0;
    end
endmodule

// File: doc/op_decoder_seq.md
Name: op_decoder_seq

Overview:
Registered, stateful successor to the combinational NeXT op decoder. It classifies each valid op word, then tracks the audio stream session: 44/22 kHz mode, sample count and inactivity timeout. It also detects runs of all-ones packets to issue a reset request. It sits between the serial packet deserialiser and the audio/keyboard datapaths.

Parameters:
OP_WIDTH, 16, op word width (>=16); decode uses opcode byte op[OP_WIDTH-1 -: 8] and sub byte op[OP_WIDTH-9 -: 8]; remaining low bits ignored
TIMEOUT, 4096, cycles without a sample op before an active audio session ends (>=2)
CNT_W, 16, width of sample counter
RESET_RUN, 2, consecutive all-ones ops required to raise reset_req (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
op  in  OP_WIDTH  op word
op_valid  in  1  op qualifies this cycle
power_on_r1  out  1  pulse: opcode c5, sub ef
kbd_led_update  out  1  pulse: opcode c5, sub 00
audio_start  out  1  pulse: opcode 0f or 1f
audio_sample  out  1  pulse: opcode c7 accepted in active session
sample_dropped  out  1  pulse: opcode c7 while idle
all_1_packet  out  1  pulse: opcode ff
reset_req  out  1  pulse: RESET_RUN-th consecutive all-ones op
unknown_op  out  1  pulse: valid op matching nothing
audio_stop  out  1  pulse: session ended by timeout or reset_req
audio_active  out  1  level: session in progress
audio_22khz  out  1  level: current/last session mode is 22 kHz
sample_count  out  CNT_W  samples accepted in current session

Behaviour:
- Only one clock and a synchronous active-high reset. Reset: state IDLE; every pulse output 0, audio_active 0, audio_22khz 0, sample_count 0, timeout and run counters 0. Reset dominates any op in the same cycle.
- Latency: all outputs registered. The op at edge N drives its outputs during cycle N+1. Pulses last exactly one cycle. No backpressure; an op is accepted every cycle op_valid=1.
- Decode priority: c5ef, c500, 1f, 0f, c7, ff, else unknown_op. An opcode c5 op with another sub byte is unknown_op.
- States: IDLE, PLAY44, PLAY22. audio_active=1 in PLAY*. audio_22khz=1 in PLAY22 and holds its last value in IDLE.
- Start op (0f/1f), any state: go to PLAY44/PLAY22, sample_count<=0, timeout counter<=0, audio_start pulse. A restart while playing does not pulse audio_stop.
- c7 in PLAY*: audio_sample pulse, sample_count+1 saturating at all-ones, timeout counter<=0.
- c7 in IDLE: sample_dropped pulse only; count unchanged.
- Timeout: in PLAY*, the counter increments each cycle with no accepted sample or start. When it equals TIMEOUT-1, go to IDLE and pulse audio_stop. sample_count holds until the next start.
- Same-cycle conflicts: a start or sample arriving on the terminal timeout cycle wins, so no stop occurs.
- all-ones run counter: increments on each ff op. On reaching RESET_RUN, pulse reset_req, clear the counter, force IDLE, clear sample_count, and pulse audio_stop if a session was active.
- Any other valid op clears the run counter. Idle cycles (op_valid=0) do not clear it.
- all_1_packet pulses on every ff op, including the one that triggers reset_req.
- op_valid=0: no decode pulses; only timeout logic runs.

Test Plan:
- Reset, then op=c5ef valid one cycle -> power_on_r1=1 for exactly one cycle, one cycle later; all other pulses 0.
- 1f00, then 3 x c712 -> audio_start, audio_22khz=1, audio_active=1; three audio_sample pulses; sample_count=3.
- 0f00, then idle TIMEOUT cycles (TIMEOUT=8 in bench) -> audio_stop pulse at 8th idle cycle, audio_active=0, sample_count holds 0. Repeat with c7 on cycle 7 -> no stop, counter restarts.
- c7aa while IDLE -> sample_dropped=1, audio_sample=0, sample_count unchanged.
- ffff, ffff (RESET_RUN=2) during PLAY44 -> two all_1_packet pulses, reset_req and audio_stop on second, state IDLE. Repeat as ffff, c500, ffff -> no reset_req, kbd_led_update once.
- CNT_W=4: 20 samples -> sample_count saturates at 15. Assert reset mid-session -> all outputs 0 next cycle.
